// File: rtl/load_store_queue.sv
// In-order load/store buffer feeding Memory.
// Snoops the CDB for pending operands and issues the oldest ready entry.
module load_store_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issueValid,
    input  logic                     issueOp,
    input  logic [TAG_W-1:0]         issueQj,
    input  logic [DATA_W-1:0]        issueVj,
    input  logic [TAG_W-1:0]         issueQk,
    input  logic [DATA_W-1:0]        issueVk,
    input  logic [DATA_W-1:0]        issueA,
    input  logic [TAG_W-1:0]         issueTag,
    output logic                     full,
    input  logic                     cdbValid,
    input  logic [TAG_W-1:0]         cdbTag,
    input  logic [DATA_W-1:0]        cdbData,
    input  logic                     memAvailable,
    output logic                     outEn,
    output logic [DATA_W-1:0]        dataIn1,
    output logic [DATA_W-1:0]        dataIn2,
    output logic                     op,
    output logic [DATA_W-1:0]        writeData,
    output logic [TAG_W-1:0]         memTag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              valid;
        logic              op;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qk;
        logic [DATA_W-1:0] vk;
        logic [DATA_W-1:0] a;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    state_t             state_q, state_d;
    logic               out_en_q, out_en_d;
    logic [DATA_W-1:0]  data_in1_q, data_in1_d;
    logic [DATA_W-1:0]  data_in2_q, data_in2_d;
    logic               op_q, op_d;
    logic [DATA_W-1:0]  write_data_q, write_data_d;
    logic [TAG_W-1:0]   mem_tag_q, mem_tag_d;

    entry_t head_e;
    entry_t new_e;
    logic   cdb_live;
    logic   head_rdy;
    logic   push;
    logic   pop;

    always_comb begin
        head_e   = ent_q[head_q];
        cdb_live = cdbValid && (cdbTag != '0);
        // Readiness uses registered tags only; a same-cycle wake-up waits a cycle.
        head_rdy = head_e.valid && (head_e.qj == '0) &&
                   (head_e.op || (head_e.qk == '0));
        push     = issueValid && !full_q;
        pop      = (state_q == S_IDLE) && head_rdy && memAvailable;

        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid && cdb_live) begin
                if (ent_q[i].qj == cdbTag) begin
                    ent_d[i].vj = cdbData;
                    ent_d[i].qj = '0;
                end
                if (ent_q[i].qk == cdbTag) begin
                    ent_d[i].vk = cdbData;
                    ent_d[i].qk = '0;
                end
            end
        end

        new_e       = '0;
        new_e.valid = 1'b1;
        new_e.op    = issueOp;
        new_e.qj    = issueQj;
        new_e.vj    = issueVj;
        new_e.qk    = issueQk;
        new_e.vk    = issueVk;
        new_e.a     = issueA;
        new_e.tag   = issueTag;
        if (cdb_live && (issueQj == cdbTag)) begin
            new_e.qj = '0;
            new_e.vj = cdbData;
        end
        if (cdb_live && (issueQk == cdbTag)) begin
            new_e.qk = '0;
            new_e.vk = cdbData;
        end

        head_d       = head_q;
        tail_d       = tail_q;
        state_d      = state_q;
        out_en_d     = 1'b0;
        data_in1_d   = data_in1_q;
        data_in2_d   = data_in2_q;
        op_d         = op_q;
        write_data_d = write_data_q;
        mem_tag_d    = mem_tag_q;

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    out_en_d     = 1'b1;
                    data_in1_d   = head_e.vj;
                    data_in2_d   = head_e.a;
                    op_d         = head_e.op;
                    write_data_d = head_e.op ? '0 : head_e.vk;
                    mem_tag_d    = head_e.op ? head_e.tag : '0;
                    ent_d[head_q].valid = 1'b0;
                    head_d       = head_q + PTR_W'(1);
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            ent_d[tail_q] = new_e;
            tail_d        = tail_q + PTR_W'(1);
        end

        count_d = count_q;
        if (push && !pop) count_d = count_q + CNT_W'(1);
        if (pop && !push) count_d = count_q - CNT_W'(1);
        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            state_q      <= S_IDLE;
            out_en_q     <= 1'b0;
            data_in1_q   <= '0;
            data_in2_q   <= '0;
            op_q         <= 1'b0;
            write_data_q <= '0;
            mem_tag_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            full_q       <= full_d;
            state_q      <= state_d;
            out_en_q     <= out_en_d;
            data_in1_q   <= data_in1_d;
            data_in2_q   <= data_in2_d;
            op_q         <= op_d;
            write_data_q <= write_data_d;
            mem_tag_q    <= mem_tag_d;
        end
    end

    assign full      = full_q;
    assign count     = count_q;
    assign outEn     = out_en_q;
    assign dataIn1   = data_in1_q;
    assign dataIn2   = data_in2_q;
    assign op        = op_q;
    assign writeData = write_data_q;
    assign memTag    = mem_tag_q;

endmodule

// File: tb/tb_load_store_queue.sv
// Scoreboard bench for load_store_queue: stimulus pushes expected issues,
// a negedge monitor pops and compares on every outEn strobe.
module tb_load_store_queue;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issueValid;
    logic              issueOp;
    logic [TAG_W-1:0]  issueQj;
    logic [DATA_W-1:0] issueVj;
    logic [TAG_W-1:0]  issueQk;
    logic [DATA_W-1:0] issueVk;
    logic [DATA_W-1:0] issueA;
    logic [TAG_W-1:0]  issueTag;
    logic              full;
    logic              cdbValid;
    logic [TAG_W-1:0]  cdbTag;
    logic [DATA_W-1:0] cdbData;
    logic              memAvailable;
    logic              outEn;
    logic [DATA_W-1:0] dataIn1;
    logic [DATA_W-1:0] dataIn2;
    logic              op;
    logic [DATA_W-1:0] writeData;
    logic [TAG_W-1:0]  memTag;
    logic [$clog2(DEPTH):0] count;

    load_store_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .issueValid(issueValid), .issueOp(issueOp),
        .issueQj(issueQj), .issueVj(issueVj),
        .issueQk(issueQk), .issueVk(issueVk),
        .issueA(issueA), .issueTag(issueTag),
        .full(full),
        .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
        .memAvailable(memAvailable),
        .outEn(outEn), .dataIn1(dataIn1), .dataIn2(dataIn2),
        .op(op), .writeData(writeData), .memTag(memTag),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic              op;
        logic [DATA_W-1:0] wd;
        logic [TAG_W-1:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic prev_en = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest expected issue.
    always @(negedge clk) begin
        if (rst_n && outEn) begin
            exp_t got;
            exp_t want;
            got = {dataIn1, dataIn2, op, writeData, memTag};
            n_cmp++;
            if (prev_en) begin
                n_fail++;
                $display("FAIL issue_rate: outEn on back-to-back cycles");
            end
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_issue: d1=%h d2=%h op=%0d wd=%h tag=%0d",
                         got.d1, got.d2, got.op, got.wd, got.tag);
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    n_fail++;
                    $display("FAIL issue: got d1=%h d2=%h op=%0d wd=%h tag=%0d want d1=%h d2=%h op=%0d wd=%h tag=%0d",
                             got.d1, got.d2, got.op, got.wd, got.tag,
                             want.d1, want.d2, want.op, want.wd, want.tag);
                end
            end
        end
        prev_en = rst_n && outEn;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic o, input logic [TAG_W-1:0] qj,
                            input logic [DATA_W-1:0] vj,
                            input logic [TAG_W-1:0] qk,
                            input logic [DATA_W-1:0] vk,
                            input logic [DATA_W-1:0] a,
                            input logic [TAG_W-1:0] tag);
        issueValid = 1'b1;
        issueOp    = o;
        issueQj    = qj;
        issueVj    = vj;
        issueQk    = qk;
        issueVk    = vk;
        issueA     = a;
        issueTag   = tag;
        cyc(1);
        issueValid = 1'b0;
    endtask

    task automatic expect_issue(input logic [DATA_W-1:0] d1,
                                input logic [DATA_W-1:0] d2, input logic o,
                                input logic [DATA_W-1:0] wd,
                                input logic [TAG_W-1:0] tag);
        exp_t e;
        e = {d1, d2, o, wd, tag};
        exp_q.push_back(e);
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdbValid = 1'b1;
        cdbTag   = t;
        cdbData  = d;
        cyc(1);
        cdbValid = 1'b0;
        cdbTag   = '0;
        cdbData  = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        issueValid = 1'b1;
        issueOp = 1'b1; issueQj = '0; issueVj = 32'd1;
        issueQk = '0; issueVk = '0; issueA = 32'd2; issueTag = 4'd1;
        cdbValid = 1'b0; cdbTag = '0; cdbData = '0;
        memAvailable = 1'b1;

        // Reset with dispatch held high
        cyc(3);
        chk("rst_count", int'(count), 0);
        chk("rst_outEn", int'(outEn), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_memTag", int'(memTag), 0);
        issueValid = 1'b0;
        rst_n = 1'b1;
        cyc(2);
        chk("idle_count", int'(count), 0);

        // Ready load issues one cycle after it lands
        expect_issue(32'd4, 32'd8, 1'b1, 32'd0, 4'd3);
        dispatch(1'b1, 4'd0, 32'd4, 4'd0, 32'd0, 32'd8, 4'd3);
        chk("load_count1", int'(count), 1);
        cyc(1);
        chk("load_outEn", int'(outEn), 1);
        chk("load_count0", int'(count), 0);
        cyc(2);

        // Store waiting on base tag 5
        expect_issue(32'd4, 32'd16, 1'b0, 32'h12345678, 4'd0);
        dispatch(1'b0, 4'd5, 32'd99, 4'd0, 32'h12345678, 32'd16, 4'd6);
        cyc(1);
        chk("store_blocked", int'(outEn), 0);
        cdb(4'd5, 32'd4);
        chk("store_wake_nobypass", int'(outEn), 0);
        cyc(1);
        chk("store_outEn", int'(outEn), 1);
        chk("store_memTag", int'(memTag), 0);
        cyc(2);

        // Fill all entries behind tag 7, overflow, then wake all
        for (int i = 0; i < DEPTH; i++) begin
            expect_issue(32'd100, 32'(i), 1'b1, 32'd0, 4'(8 + i));
            dispatch(1'b1, 4'd7, 32'd55, 4'd0, 32'd0, 32'(i), 4'(8 + i));
        end
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), DEPTH);
        dispatch(1'b1, 4'd0, 32'd1, 4'd0, 32'd0, 32'd77, 4'd15);
        chk("drop_count", int'(count), DEPTH);
        cdb(4'd7, 32'd100);
        cyc(1);
        chk("drain_first", int'(count), DEPTH - 1);
        cyc(8);
        chk("drain_count", int'(count), 0);
        chk("drain_full", int'(full), 0);

        // Dispatch coincident with its producer on the CDB
        expect_issue(32'd9, 32'd3, 1'b1, 32'd0, 4'd5);
        cdbValid = 1'b1; cdbTag = 4'd2; cdbData = 32'd9;
        dispatch(1'b1, 4'd2, 32'd77, 4'd0, 32'd0, 32'd3, 4'd5);
        cdbValid = 1'b0; cdbTag = '0; cdbData = '0;
        cyc(4);

        // Memory busy holds a ready head
        memAvailable = 1'b0;
        expect_issue(32'd20, 32'd4, 1'b1, 32'd0, 4'd9);
        dispatch(1'b1, 4'd0, 32'd20, 4'd0, 32'd0, 32'd4, 4'd9);
        cyc(3);
        chk("busy_outEn", int'(outEn), 0);
        chk("busy_count", int'(count), 1);
        memAvailable = 1'b1;
        cyc(1);
        chk("avail_outEn", int'(outEn), 1);
        cyc(2);

        // Reset mid-queue discards everything
        memAvailable = 1'b0;
        dispatch(1'b1, 4'd0, 32'd1, 4'd0, 32'd0, 32'd1, 4'd1);
        dispatch(1'b0, 4'd0, 32'd2, 4'd0, 32'd5, 32'd2, 4'd2);
        chk("pre_rst_count", int'(count), 2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        cyc(1);
        rst_n = 1'b1;
        memAvailable = 1'b1;
        cyc(6);
        chk("post_rst_count", int'(count), 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
